// File: rtl/rs_wakeup_select.sv
// Per-FU reservation station: holds dispatched packets with dependency masks cleared by
// wakeup broadcasts, and issues the oldest ready entry over a valid/ready handshake.
module rs_wakeup_select #(
    parameter int  RS_ENTRIES = 4,
    parameter int  NUM_FUS    = 4,
    parameter int  FU_ID      = 0,
    parameter int  PKT_W      = 64,
    localparam int TAG_N      = RS_ENTRIES * NUM_FUS,
    localparam int IDX_W      = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1,
    localparam int TAG_W      = (TAG_N > 1) ? $clog2(TAG_N) : 1,
    localparam int OCC_W      = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [PKT_W-1:0] disp_pkt,
    input  logic [TAG_N-1:0] dependency_mask,
    output logic [IDX_W-1:0] rs_entry_idx,
    output logic             rs_full,
    input  logic [TAG_N-1:0] wake_vec,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [PKT_W-1:0] iss_pkt,
    output logic [TAG_W-1:0] iss_tag,
    output logic [OCC_W-1:0] occupancy
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // Entry state
    logic [RS_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_N-1:0]      mask_q  [RS_ENTRIES];
    logic [TAG_N-1:0]      mask_d  [RS_ENTRIES];
    logic [PKT_W-1:0]      pkt_q   [RS_ENTRIES];
    logic [PKT_W-1:0]      pkt_d   [RS_ENTRIES];
    // older_q[i][j] = 1 means entry j was allocated before entry i
    logic [RS_ENTRIES-1:0] older_q [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] older_d [RS_ENTRIES];

    lock_state_t      state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    // Combinational datapath
    logic [RS_ENTRIES-1:0] ready;
    logic [RS_ENTRIES-1:0] sel_onehot;
    logic [RS_ENTRIES-1:0] alloc_onehot;
    logic [RS_ENTRIES-1:0] free_onehot;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_any;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  alloc_found;
    logic [IDX_W-1:0]      issue_idx;
    logic                  iss_valid_int;
    logic                  fire;
    logic                  accept;
    logic [OCC_W-1:0]      occ_count;
    logic [TAG_W-1:0]      issue_tag;
    logic [TAG_W-1:0]      alloc_tag;

    // Lowest-index free slot, from registered valids only (a freed slot is not bypassed).
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_idx   = IDX_W'(i);
                alloc_found = 1'b1;
            end
        end
    end

    assign rs_full      = &valid_q;
    assign rs_entry_idx = alloc_idx;
    assign accept       = disp_valid && !rs_full && !flush;

    // Age-matrix select yields at most one hot bit; encode it.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (sel_onehot[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel_any = |sel_onehot;

    // Once a candidate has been presented and refused, it stays on the port until taken.
    always_comb begin
        issue_idx     = sel_idx;
        iss_valid_int = sel_any;
        if (state_q == ST_LOCKED) begin
            issue_idx     = lock_idx_q;
            iss_valid_int = valid_q[lock_idx_q];
        end
    end

    assign fire      = iss_valid_int && iss_ready;
    assign issue_tag = TAG_W'(FU_ID * RS_ENTRIES + int'(issue_idx));
    assign alloc_tag = TAG_W'(FU_ID * RS_ENTRIES + int'(alloc_idx));

    assign iss_valid = iss_valid_int;
    assign iss_pkt   = iss_valid_int ? pkt_q[issue_idx] : '0;
    assign iss_tag   = iss_valid_int ? issue_tag : '0;

    always_comb begin
        occ_count = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            occ_count = occ_count + OCC_W'(valid_q[i]);
        end
    end

    assign occupancy = occ_count;

    // Per-entry next-state
    for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_entry
        assign ready[gi]        = valid_q[gi] && (mask_q[gi] == '0);
        assign sel_onehot[gi]   = ready[gi] && ((older_q[gi] & ready) == '0);
        assign alloc_onehot[gi] = accept && (alloc_idx == IDX_W'(gi));
        assign free_onehot[gi]  = fire && !flush && (issue_idx == IDX_W'(gi));

        assign valid_d[gi] = flush ? 1'b0
                                   : (alloc_onehot[gi] || (valid_q[gi] && !free_onehot[gi]));

        // A wakeup in the dispatch cycle is applied to the incoming mask as well.
        assign mask_d[gi] = alloc_onehot[gi] ? (dependency_mask & ~wake_vec)
                                             : (mask_q[gi] & ~wake_vec);

        assign pkt_d[gi] = alloc_onehot[gi] ? disp_pkt : pkt_q[gi];

        // New entry is younger than every survivor; stale column bits of its slot are cleared.
        assign older_d[gi] = alloc_onehot[gi] ? (valid_q & ~free_onehot)
                                              : (older_q[gi] & ~alloc_onehot);
    end

    // Issue lock FSM
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (iss_valid_int && !iss_ready) begin
                    state_d    = ST_LOCKED;
                    lock_idx_d = sel_idx;
                end
            end
            ST_LOCKED: begin
                if (iss_ready) begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
        if (flush) begin
            state_d = ST_UNLOCKED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            state_q    <= ST_UNLOCKED;
            lock_idx_q <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                mask_q[i]  <= '0;
                pkt_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                mask_q[i]  <= mask_d[i];
                pkt_q[i]   <= pkt_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

    // An entry may never wait on its own global tag.
    a_no_self_dep: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> !dependency_mask[alloc_tag]);

    a_lock_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_LOCKED) |-> valid_q[lock_idx_q]);

endmodule

// File: tb/tb_rs_wakeup_select.sv
// Directed bench for rs_wakeup_select: a sequence-number model of the station is checked
// against the DUT every cycle, with literal expectations pinning key points of each scenario.
`timescale 1ns/1ps
module tb_rs_wakeup_select;

    localparam int RS_ENTRIES = 4;
    localparam int NUM_FUS    = 4;
    localparam int FU_ID      = 0;
    localparam int PKT_W      = 64;
    localparam int TAG_N      = 16;
    localparam int IDX_W      = 2;
    localparam int TAG_W      = 4;
    localparam int OCC_W      = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             disp_valid = 1'b0;
    logic [PKT_W-1:0] disp_pkt = '0;
    logic [TAG_N-1:0] dependency_mask = '0;
    logic [TAG_N-1:0] wake_vec = '0;
    logic             iss_ready = 1'b0;
    logic [IDX_W-1:0] rs_entry_idx;
    logic             rs_full;
    logic             iss_valid;
    logic [PKT_W-1:0] iss_pkt;
    logic [TAG_W-1:0] iss_tag;
    logic [OCC_W-1:0] occupancy;

    rs_wakeup_select #(
        .RS_ENTRIES(RS_ENTRIES),
        .NUM_FUS   (NUM_FUS),
        .FU_ID     (FU_ID),
        .PKT_W     (PKT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_pkt       (disp_pkt),
        .dependency_mask(dependency_mask),
        .rs_entry_idx   (rs_entry_idx),
        .rs_full        (rs_full),
        .wake_vec       (wake_vec),
        .iss_valid      (iss_valid),
        .iss_ready      (iss_ready),
        .iss_pkt        (iss_pkt),
        .iss_tag        (iss_tag),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: entries carry an allocation sequence number; smaller = older.
    bit               m_valid [RS_ENTRIES];
    logic [TAG_N-1:0] m_mask  [RS_ENTRIES];
    logic [PKT_W-1:0] m_pkt   [RS_ENTRIES];
    int               m_age   [RS_ENTRIES];
    int               m_next_age;
    bit               m_hold;
    int               m_hold_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_pick();
        int best;
        if (m_hold) return m_hold_idx;
        best = -1;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (m_valid[i] && m_mask[i] == '0 && (best < 0 || m_age[i] < m_age[best])) best = i;
        end
        return best;
    endfunction

    function automatic int m_free_slot();
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (!m_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic int m_count();
        int c;
        c = 0;
        for (int i = 0; i < RS_ENTRIES; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_mask[i]  = '0;
            m_pkt[i]   = '0;
            m_age[i]   = 0;
        end
        m_next_age = 0;
        m_hold     = 1'b0;
        m_hold_idx = 0;
    endtask

    task automatic model_edge();
        int pick;
        int slot;
        pick = m_pick();
        slot = m_free_slot();
        if (flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) m_valid[i] = 1'b0;
            m_hold = 1'b0;
            $display("t=%0t flush", $time);
            return;
        end
        m_hold     = (pick >= 0) && !iss_ready;
        m_hold_idx = pick;
        for (int i = 0; i < RS_ENTRIES; i++) m_mask[i] = m_mask[i] & ~wake_vec;
        if (pick >= 0 && iss_ready) begin
            m_valid[pick] = 1'b0;
            $display("t=%0t issue tag=%0d pkt=%0h", $time, FU_ID * RS_ENTRIES + pick, m_pkt[pick]);
        end
        if (disp_valid && slot >= 0) begin
            m_valid[slot] = 1'b1;
            m_mask[slot]  = dependency_mask & ~wake_vec;
            m_pkt[slot]   = disp_pkt;
            m_age[slot]   = m_next_age;
            m_next_age++;
            $display("t=%0t dispatch slot=%0d pkt=%0h mask=%0h", $time, slot, disp_pkt, m_mask[slot]);
        end else if (disp_valid) begin
            $display("t=%0t dispatch stalled pkt=%0h", $time, disp_pkt);
        end
    endtask

    task automatic compare_model();
        int pick;
        int slot;
        pick = m_pick();
        slot = m_free_slot();
        chk("cyc_rs_full", 64'(rs_full), 64'(slot < 0));
        chk("cyc_entry_idx", 64'(rs_entry_idx), 64'((slot < 0) ? 0 : slot));
        chk("cyc_occupancy", 64'(occupancy), 64'(m_count()));
        chk("cyc_iss_valid", 64'(iss_valid), 64'(pick >= 0));
        chk("cyc_iss_tag", 64'(iss_tag), 64'((pick >= 0) ? FU_ID * RS_ENTRIES + pick : 0));
        chk("cyc_iss_pkt", iss_pkt, (pick >= 0) ? m_pkt[pick] : 64'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        @(negedge clk);
        compare_model();
    endtask

    task automatic step(input bit f, input bit dv, input logic [PKT_W-1:0] pkt,
                        input logic [TAG_N-1:0] dep, input logic [TAG_N-1:0] wk, input bit rdy);
        flush           = f;
        disp_valid      = dv;
        disp_pkt        = pkt;
        dependency_mask = dep;
        wake_vec        = wk;
        iss_ready       = rdy;
        cyc();
    endtask

    initial begin
        int exp_tags[4];
        model_reset();

        // Reset state
        @(negedge clk);
        compare_model();
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_rs_full", 64'(rs_full), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_iss_tag", 64'(iss_tag), 64'd0);
        chk("rst_iss_pkt", iss_pkt, 64'd0);
        rst_n = 1'b1;

        // 1: fill, overflow dropped, drain in age order
        for (int k = 0; k < 4; k++) begin
            chk("t1_alloc_idx", 64'(rs_entry_idx), 64'(k));
            step(0, 1, 64'd100 + 64'(k), 16'h0000, 16'h0000, 0);
        end
        chk("t1_full", 64'(rs_full), 64'd1);
        chk("t1_occ4", 64'(occupancy), 64'd4);
        step(0, 1, 64'd999, 16'h0000, 16'h0000, 0);
        chk("t1_drop_occ", 64'(occupancy), 64'd4);
        chk("t1_locked_pkt", iss_pkt, 64'd100);
        for (int k = 0; k < 4; k++) begin
            chk("t1_drain_tag", 64'(iss_tag), 64'(k));
            step(0, 0, 64'd0, 16'h0000, 16'h0000, 1);
        end
        chk("t1_empty_valid", 64'(iss_valid), 64'd0);

        // 2: younger ready entry bypasses blocked older one; wakeup frees the older
        step(0, 1, 64'd200, 16'h0020, 16'h0000, 1);
        chk("t2_blocked", 64'(iss_valid), 64'd0);
        step(0, 1, 64'd201, 16'h0000, 16'h0000, 1);
        chk("t2_first_tag", 64'(iss_tag), 64'd1);
        chk("t2_first_pkt", iss_pkt, 64'd201);
        step(0, 0, 64'd0, 16'h0000, 16'h0020, 1);
        chk("t2_second_tag", 64'(iss_tag), 64'(FU_ID * 4 + 0));
        chk("t2_second_pkt", iss_pkt, 64'd200);
        step(0, 0, 64'd0, 16'h0000, 16'h0000, 1);
        chk("t2_occ0", 64'(occupancy), 64'd0);

        // 3: same-cycle wakeup of the dispatched dependency
        step(0, 1, 64'd300, 16'h0200, 16'h0200, 0);
        chk("t3_ready_next", 64'(iss_valid), 64'd1);
        chk("t3_tag", 64'(iss_tag), 64'd0);
        step(0, 0, 64'd0, 16'h0000, 16'h0000, 1);

        // 4: lock holds younger entry2 while older entry0 wakes
        step(0, 1, 64'd400, 16'h0040, 16'h0000, 0);
        step(0, 1, 64'd401, 16'h0080, 16'h0000, 0);
        step(0, 1, 64'd402, 16'h0000, 16'h0000, 0);
        chk("t4_present2", 64'(iss_tag), 64'd2);
        step(0, 0, 64'd0, 16'h0000, 16'h0040, 0);
        chk("t4_hold_tag", 64'(iss_tag), 64'd2);
        chk("t4_hold_pkt", iss_pkt, 64'd402);
        step(0, 0, 64'd0, 16'h0000, 16'h0000, 0);
        chk("t4_still_tag", 64'(iss_tag), 64'd2);
        step(0, 0, 64'd0, 16'h0000, 16'h0000, 1);
        chk("t4_entry0_next", 64'(iss_tag), 64'd0);
        step(0, 0, 64'd0, 16'h0000, 16'h0000, 1);
        chk("t4_entry1_blocked", 64'(iss_valid), 64'd0);
        step(0, 0, 64'd0, 16'h0000, 16'h0080, 1);
        chk("t4_entry1_tag", 64'(iss_tag), 64'd1);
        step(0, 0, 64'd0, 16'h0000, 16'h0000, 1);
        chk("t4_occ0", 64'(occupancy), 64'd0);

        // 5: full station, issue + dispatch same cycle -> refused, accepted next cycle
        for (int k = 0; k < 4; k++) step(0, 1, 64'd500 + 64'(k), 16'h0000, 16'h0000, 0);
        chk("t5_full", 64'(rs_full), 64'd1);
        step(0, 1, 64'd504, 16'h0000, 16'h0000, 1);
        chk("t5_occ3", 64'(occupancy), 64'd3);
        chk("t5_not_full", 64'(rs_full), 64'd0);
        chk("t5_free_idx", 64'(rs_entry_idx), 64'd0);
        step(0, 1, 64'd504, 16'h0000, 16'h0000, 0);
        chk("t5_occ4", 64'(occupancy), 64'd4);
        exp_tags = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            chk("t5_order_tag", 64'(iss_tag), 64'(exp_tags[k]));
            if (k == 3) chk("t5_new_pkt", iss_pkt, 64'd504);
            step(0, 0, 64'd0, 16'h0000, 16'h0000, 1);
        end

        // 6: flush with three entries and lock active
        for (int k = 0; k < 3; k++) step(0, 1, 64'd600 + 64'(k), 16'h0000, 16'h0000, 0);
        chk("t6_occ3", 64'(occupancy), 64'd3);
        step(1, 1, 64'd603, 16'h0000, 16'h0000, 1);
        chk("t6_occ0", 64'(occupancy), 64'd0);
        chk("t6_iss_valid", 64'(iss_valid), 64'd0);
        chk("t6_rs_full", 64'(rs_full), 64'd0);
        step(0, 1, 64'd604, 16'h0000, 16'h0000, 0);
        chk("t6_post_tag", 64'(iss_tag), 64'd0);
        chk("t6_post_pkt", iss_pkt, 64'd604);
        step(0, 0, 64'd0, 16'h0000, 16'h0000, 1);

        // 7: asynchronous reset in mid-operation
        step(0, 1, 64'd700, 16'h0000, 16'h0000, 0);
        step(0, 1, 64'd701, 16'h1000, 16'h0000, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_occ", 64'(occupancy), 64'd0);
        chk("t7_async_valid", 64'(iss_valid), 64'd0);
        model_reset();
        step(0, 0, 64'd0, 16'h0000, 16'h0000, 0);
        rst_n = 1'b1;
        step(0, 1, 64'd710, 16'h0000, 16'h0000, 0);
        chk("t7_after_tag", 64'(iss_tag), 64'd0);
        chk("t7_after_pkt", iss_pkt, 64'd710);
        step(0, 0, 64'd0, 16'h0000, 16'h0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
